// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite register-bank responder with four 32-bit registers in a
// 16-byte window at BASE_ADDR. REG0 and REG1 are read/write. SUM (REG0+REG1) and
// WCNT (the count of OKAY writes) are read-only.
// Optional build macro AXIL_REG_SLAVE_STRB_EN: when it is defined, REG0 and REG1 honour
// per-byte write strobes. When it is undefined, every OKAY write replaces the whole word.
module axil_reg_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned           NumBytes   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] BaseAddr   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [RESP_WIDTH-1:0] RespOkay   = '0;
  localparam logic [RESP_WIDTH-1:0] RespSlvErr = RESP_WIDTH'(2);

  typedef enum logic [1:0] {WIdle, WHaveAw, WHaveW, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  // Keeps every ready low while in reset; readies appear on the first edge afterwards.
  logic ready_en_q;

  logic [DATA_WIDTH-1:0] reg0_q, reg0_d;
  logic [DATA_WIDTH-1:0] reg1_q, reg1_d;
  logic [DATA_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0] rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, wr_mask, rd_word;
  logic wr_ok, rd_in_win;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // The write address and data come from the live bus in the handshake cycle and from
  // the capture registers otherwise.
  assign wr_addr = aw_hs ? s_axi_awaddr : awaddr_q;
  assign wr_data = w_hs ? s_axi_wdata : wdata_q;

  // Only REG0 (offset 0x0) and REG1 (offset 0x4) accept writes.
  assign wr_ok = (wr_addr[ADDR_WIDTH-1:4] == BaseAddr[ADDR_WIDTH-1:4]) &&
                 (wr_addr[1:0] == 2'b00) && !wr_addr[3];

  assign rd_in_win = (s_axi_araddr[ADDR_WIDTH-1:4] == BaseAddr[ADDR_WIDTH-1:4]) &&
                     (s_axi_araddr[1:0] == 2'b00);

`ifdef AXIL_REG_SLAVE_STRB_EN
  logic [NumBytes-1:0] wstrb_q;
  logic [NumBytes-1:0] wr_strb;
  logic                unused_wstrb;

  assign wr_strb      = w_hs ? s_axi_wstrb[NumBytes-1:0] : wstrb_q;
  assign unused_wstrb = s_axi_wstrb[NumBytes];

  // Expand the byte strobes into a bit mask.
  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < NumBytes; i++) begin
      wr_mask[i*8 +: 8] = {8{wr_strb[i]}};
    end
  end

  // Capture the strobes alongside the write data.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wstrb_q <= '0;
    end else begin
      wstrb_q <= wr_strb;
    end
  end
`else
  logic unused_wstrb;

  assign unused_wstrb = ^s_axi_wstrb;
  assign wr_mask      = '1;
`endif

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------

  // Write state register; a reset aborts any transaction in flight.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_q <= WIdle;
    end else begin
      w_state_q <= w_state_d;
    end
  end

  // Write next state: collect AW and W in either order, then hold the response.
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs && w_hs) begin
          w_state_d = WResp;
        end else if (aw_hs) begin
          w_state_d = WHaveAw;
        end else if (w_hs) begin
          w_state_d = WHaveW;
        end
      end
      WHaveAw: if (w_hs)         w_state_d = WResp;
      WHaveW:  if (aw_hs)        w_state_d = WResp;
      WResp:   if (s_axi_bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  // Write channel outputs.
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        s_axi_awready = ready_en_q;
        s_axi_wready  = ready_en_q;
      end
      WHaveAw: s_axi_wready  = 1'b1;
      WHaveW:  s_axi_awready = 1'b1;
      WResp:   s_axi_bvalid  = 1'b1;
      default: ;
    endcase
  end

  assign s_axi_bresp = bresp_q;

  // Registers update on the same edge that raises bvalid.
  assign w_commit = (w_state_q != WResp) && (w_state_d == WResp);

  // Register-bank next state and the write response.
  always_comb begin
    reg0_d  = reg0_q;
    reg1_d  = reg1_q;
    wcnt_d  = wcnt_q;
    bresp_d = bresp_q;
    if (w_commit) begin
      bresp_d = wr_ok ? RespOkay : RespSlvErr;
      if (wr_ok) begin
        wcnt_d = wcnt_q + 1'b1;
        if (wr_addr[2]) begin
          reg1_d = (reg1_q & ~wr_mask) | (wr_data & wr_mask);
        end else begin
          reg0_d = (reg0_q & ~wr_mask) | (wr_data & wr_mask);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------

  // Read state register.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state_q <= RIdle;
    end else begin
      r_state_q <= r_state_d;
    end
  end

  // Read next state: accept one address, then hold the data until it is taken.
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_hs)        r_state_d = RData;
      RData:   if (s_axi_rready) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Read channel outputs.
  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    unique case (r_state_q)
      RIdle:   s_axi_arready = ready_en_q;
      RData:   s_axi_rvalid  = 1'b1;
      default: ;
    endcase
  end

  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;

  // Read mux; it uses pre-edge register values, so a read that coincides with a write
  // returns the old contents.
  always_comb begin
    rd_word = '0;
    unique case (s_axi_araddr[3:2])
      2'd0: rd_word = reg0_q;
      2'd1: rd_word = reg1_q;
      2'd2: rd_word = reg0_q + reg1_q;
      2'd3: rd_word = wcnt_q;
    endcase
  end

  // Latch read data and response on the AR handshake.
  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      rdata_d = rd_in_win ? rd_word : '0;
      rresp_d = rd_in_win ? RespOkay : RespSlvErr;
    end
  end

  // Datapath registers.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      ready_en_q <= 1'b0;
      reg0_q     <= '0;
      reg1_q     <= '0;
      wcnt_q     <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      bresp_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      reg0_q     <= reg0_d;
      reg1_q     <= reg1_d;
      wcnt_q     <= wcnt_d;
      awaddr_q   <= wr_addr;
      wdata_q    <= wr_data;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule
